// File: rtl/vga_timing_if.sv
// Raster timing bundle driven by vga_timing_gen and consumed by the pixel-colour stage.
interface vga_timing_if;
  logic       pix_en;
  logic [9:0] hCount;
  logic [9:0] vCount;
  logic       bright;
  logic       hSync;
  logic       vSync;
  logic       line_start;
  logic       frame_start;
  logic [7:0] frame_count;

  modport master (
    output pix_en, hCount, vCount, bright, hSync, vSync,
           line_start, frame_start, frame_count
  );

  modport slave (
    input  pix_en, hCount, vCount, bright, hSync, vSync,
           line_start, frame_start, frame_count
  );
endinterface

// File: rtl/vga_timing_gen.sv
// VGA raster timing: pixel-enable divider, display-coordinate counters and
// registered decodes that line up with the counters presented in the same cycle.
module vga_timing_gen #(
  parameter int CLK_DIV   = 4,
  parameter int H_VISIBLE = 640,
  parameter int H_FP      = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BP      = 48,
  parameter int V_VISIBLE = 480,
  parameter int V_FP      = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BP      = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic          clk,
  input  logic          rst,
  vga_timing_if.master  vga
);

  localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam logic [3:0] TICK_LAST    = 4'(CLK_DIV - 1);
  localparam logic [9:0] H_LAST       = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST       = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS        = 10'(H_VISIBLE);
  localparam logic [9:0] V_VIS        = 10'(V_VISIBLE);
  localparam logic [9:0] H_SYNC_START = 10'(H_VISIBLE + H_FP);
  localparam logic [9:0] H_SYNC_END   = 10'(H_VISIBLE + H_FP + H_SYNC);
  localparam logic [9:0] V_SYNC_START = 10'(V_VISIBLE + V_FP);
  localparam logic [9:0] V_SYNC_END   = 10'(V_VISIBLE + V_FP + V_SYNC);
  localparam logic       SYNC_ACT     = (SYNC_POL != 0);

  logic [3:0] tick_cnt, tick_nxt;
  logic       pix_en_q, pix_en_nxt;
  logic [9:0] h_q, h_nxt;
  logic [9:0] v_q, v_nxt;
  logic       h_wrap, v_wrap;
  logic       bright_q, bright_nxt;
  logic       hsync_q, hsync_nxt;
  logic       vsync_q, vsync_nxt;
  logic       line_q, frame_q;
  logic [7:0] fcount_q, fcount_nxt;

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    tick_nxt   = tick_cnt + 4'd1;
    pix_en_nxt = 1'b0;
    h_nxt      = h_q;
    v_nxt      = v_q;
    h_wrap     = 1'b0;
    v_wrap     = 1'b0;
    fcount_nxt = fcount_q;

    if (tick_cnt == TICK_LAST) begin
      tick_nxt = 4'd0;
    end
    // pix_en is high in the cycle whose tick_cnt is the last divider step.
    pix_en_nxt = (tick_nxt == TICK_LAST);

    if (pix_en_q) begin
      if (h_q == H_LAST) begin
        h_wrap = 1'b1;
        h_nxt  = 10'd0;
      end else begin
        h_nxt  = h_q + 10'd1;
      end
    end

    if (h_wrap) begin
      if (v_q == V_LAST) begin
        v_wrap     = 1'b1;
        v_nxt      = 10'd0;
        fcount_nxt = fcount_q + 8'd1;
      end else begin
        v_nxt      = v_q + 10'd1;
      end
    end
  end

  // Decodes use next-state counters so the registered outputs match the
  // counter values that appear alongside them.
  always_comb begin
    bright_nxt = (h_nxt < H_VIS) && (v_nxt < V_VIS);
    hsync_nxt  = ((h_nxt >= H_SYNC_START) && (h_nxt < H_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
    vsync_nxt  = ((v_nxt >= V_SYNC_START) && (v_nxt < V_SYNC_END)) ? SYNC_ACT : ~SYNC_ACT;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      tick_cnt <= 4'd0;
      pix_en_q <= 1'b0;
      h_q      <= 10'd0;
      v_q      <= 10'd0;
      bright_q <= 1'b0;
      hsync_q  <= ~SYNC_ACT;
      vsync_q  <= ~SYNC_ACT;
      line_q   <= 1'b0;
      frame_q  <= 1'b0;
      fcount_q <= 8'd0;
    end else begin
      tick_cnt <= tick_nxt;
      pix_en_q <= pix_en_nxt;
      h_q      <= h_nxt;
      v_q      <= v_nxt;
      bright_q <= bright_nxt;
      hsync_q  <= hsync_nxt;
      vsync_q  <= vsync_nxt;
      line_q   <= h_wrap;
      frame_q  <= v_wrap;
      fcount_q <= fcount_nxt;
    end
  end

  assign vga.pix_en      = pix_en_q;
  assign vga.hCount      = h_q;
  assign vga.vCount      = v_q;
  assign vga.bright      = bright_q;
  assign vga.hSync       = hsync_q;
  assign vga.vSync       = vsync_q;
  assign vga.line_start  = line_q;
  assign vga.frame_start = frame_q;
  assign vga.frame_count = fcount_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: two shrunken rasters (CLK_DIV 4 / active-low sync and
// CLK_DIV 1 / active-high sync) checked every cycle against an arithmetic raster model.
module tb_vga_timing_gen;

  localparam int HV = 12, HF = 2, HS = 3, HB = 3;
  localparam int VV = 6,  VF = 1, VS = 2, VB = 1;
  localparam int HT = HV + HF + HS + HB;   // 20
  localparam int VT = VV + VF + VS + VB;   // 10
  localparam int FT = HT * VT;             // 200 pixels per frame

  typedef struct packed {
    logic       pix_en;
    logic [9:0] h;
    logic [9:0] v;
    logic       bright;
    logic       hs;
    logic       vs;
    logic       ls;
    logic       fs;
    logic [7:0] fc;
  } out_t;

  logic clk = 1'b0;
  logic rst4, rst1;

  vga_timing_if vga4();
  vga_timing_if vga1();

  vga_timing_gen #(
    .CLK_DIV(4), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(0)
  ) u_div4 (.clk(clk), .rst(rst4), .vga(vga4));

  vga_timing_gen #(
    .CLK_DIV(1), .H_VISIBLE(HV), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
    .V_VISIBLE(VV), .V_FP(VF), .V_SYNC(VS), .V_BP(VB), .SYNC_POL(1)
  ) u_div1 (.clk(clk), .rst(rst1), .vga(vga1));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Pixels advanced by cycle k after reset: edges that follow a cycle with
  // pix_en high, where pix_en is high when (cycle mod div) == div-1, cycle 0 excluded.
  function automatic int advances(input int k, input int div);
    if (k == 0) return 0;
    return k / div - ((div == 1) ? 1 : 0);
  endfunction

  function automatic out_t expect_out(input int k, input int div, input logic pol);
    out_t o;
    int   p, pp, h, v;
    if (k == 0) begin
      o = '0;
      o.hs = ~pol;
      o.vs = ~pol;
      return o;
    end
    p  = advances(k, div);
    pp = advances(k - 1, div);
    h  = p % HT;
    v  = (p / HT) % VT;
    o.pix_en = ((k % div) == div - 1);
    o.h      = 10'(h);
    o.v      = 10'(v);
    o.bright = (h < HV) && (v < VV);
    o.hs     = (h >= HV + HF && h < HV + HF + HS) ? pol : ~pol;
    o.vs     = (v >= VV + VF && v < VV + VF + VS) ? pol : ~pol;
    o.ls     = (p != pp) && (h == 0);
    o.fs     = (p != pp) && ((p % FT) == 0);
    o.fc     = 8'((p / FT) % 256);
    return o;
  endfunction

  out_t obs4, obs1;
  assign obs4 = {vga4.pix_en, vga4.hCount, vga4.vCount, vga4.bright, vga4.hSync,
                 vga4.vSync, vga4.line_start, vga4.frame_start, vga4.frame_count};
  assign obs1 = {vga1.pix_en, vga1.hCount, vga1.vCount, vga1.bright, vga1.hSync,
                 vga1.vSync, vga1.line_start, vga1.frame_start, vga1.frame_count};

  // Cycles since the last edge that sampled reset.
  int k4 = 0, k1 = 0, cyc = 0;
  bit live = 1'b0;

  always @(posedge clk) begin
    live <= 1'b1;
    cyc  <= cyc + 1;
    k4   <= rst4 ? 0 : k4 + 1;
    k1   <= rst1 ? 0 : k1 + 1;
  end

  int last_ls4 = -1;
  int bcnt1    = 0;
  bit bvalid1  = 1'b0;
  int nfs1     = 0;
  bit wrap_seen = 1'b0;

  always @(negedge clk) begin
    if (live) begin
      check("div4_cycle", 64'(obs4), 64'(expect_out(k4, 4, 1'b0)));
      check("div1_cycle", 64'(obs1), 64'(expect_out(k1, 1, 1'b1)));

      if (k4 == 0) last_ls4 = -1;
      if (vga4.line_start) begin
        if (last_ls4 >= 0) check("div4_line_gap", 64'(cyc - last_ls4), 64'(HT * 4));
        last_ls4 = cyc;
      end

      if (k1 == 0) begin
        bcnt1   = 0;
        bvalid1 = 1'b0;
        nfs1    = 0;
      end
      if (vga1.frame_start) begin
        if (bvalid1) check("div1_bright_per_frame", 64'(bcnt1), 64'(HV * VV));
        bvalid1 = 1'b1;
        bcnt1   = 0;
        nfs1++;
        if (nfs1 == 256) begin
          check("div1_fc_wrap", 64'(vga1.frame_count), 64'd0);
          wrap_seen = 1'b1;
        end
      end
      if (vga1.bright) bcnt1++;
    end
  end

  initial begin
    out_t rv;
    bit   found;
    int   budget;

    rst4 = 1'b1;
    rst1 = 1'b1;
    repeat (4) @(negedge clk);
    rv = '0; rv.hs = 1'b1; rv.vs = 1'b1;
    check("rst_hold_div4", 64'(obs4), 64'(rv));
    rv = '0;
    check("rst_hold_div1", 64'(obs1), 64'(rv));

    rst4 = 1'b0;
    rst1 = 1'b0;
    repeat (2) @(negedge clk);
    check("div4_pix_en_early", 64'(vga4.pix_en), 64'd0);
    @(negedge clk);
    check("div4_pix_en_first", 64'(vga4.pix_en), 64'd1);
    @(negedge clk);
    check("div4_h_after_first", 64'({vga4.pix_en, vga4.hCount}), 64'({1'b0, 10'd1}));

    repeat (FT * 4 * 2) @(negedge clk);

    // Late-line, mid-frame reset on the divided raster.
    found = 1'b0;
    for (int i = 0; i < 4 * FT * 2 && !found; i++) begin
      @(negedge clk);
      if (vga4.hCount == 10'd15 && vga4.vCount == 10'd7) found = 1'b1;
    end
    check("div4_reach_15_7", 64'(found), 64'd1);
    if (found) begin
      rst4 = 1'b1;
      @(negedge clk);
      rst4 = 1'b0;
      rv = '0; rv.hs = 1'b1; rv.vs = 1'b1;
      check("div4_mid_reset", 64'(obs4), 64'(rv));
    end

    // Random resets on the divided raster while the undivided one runs 256 frames.
    budget = 60000;
    while (!wrap_seen && budget > 0) begin
      int gap;
      gap = int'($urandom_range(20, 1500));
      repeat (gap) @(negedge clk);
      budget -= gap;
      rst4 = 1'b1;
      repeat ($urandom_range(1, 3)) @(negedge clk);
      rst4 = 1'b0;
    end
    check("div1_wrap_seen", 64'(wrap_seen), 64'd1);

    for (int i = 0; i < 5; i++) begin
      repeat ($urandom_range(10, 300)) @(negedge clk);
      rst1 = 1'b1;
      repeat ($urandom_range(1, 2)) @(negedge clk);
      rst1 = 1'b0;
    end
    repeat (FT * 2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
